cam_pixel_packer: RTL and testbench

CAM_PIXEL_PACKER -- requirements
Module: cam_pixel_packer

---
 rtl/cam_pkg.sv | 23 ++
 rtl/cam_rgb_reduce.sv | 16 +
 rtl/cam_pixel_packer.sv | 159 +++++++++++++++
 tb/tb_cam_pixel_packer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared types and defaults for the camera pixel packer.
// FSM encoding, frame geometry defaults and the registered input bundle.
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SYNC       = 3'd1,
    ST_WAIT_FRAME = 3'd2,
    ST_CAPTURE    = 3'd3,
    ST_DONE       = 3'd4
  } cam_state_e;

  localparam int H_ACTIVE_DEF = 160;
  localparam int V_ACTIVE_DEF = 120;
  localparam int FB_DEPTH     = H_ACTIVE_DEF * V_ACTIVE_DEF;

  typedef struct packed {
    logic [7:0] data;
    logic       href;
    logic       vsync;
  } cam_in_t;

endpackage

// File: rtl/cam_rgb_reduce.sv
// cam_rgb_reduce: combinational RGB565 (hi,lo byte) to RGB332 reduction.
// Ports: hi_i/lo_i sensor byte pair, rgb332_o = {R[4:2], G[5:3], B[4:3]}.
module cam_rgb_reduce (
  input  logic [7:0] hi_i,
  input  logic [7:0] lo_i,
  output logic [7:0] rgb332_o
);

  // hi = RRRRRGGG, lo = GGGBBBBB; only the field MSBs survive.
  assign rgb332_o = {hi_i[7:5], hi_i[2:0], lo_i[4:3]};

  // Dropped colour LSBs are intentionally discarded.
  logic unused_lsbs;
  assign unused_lsbs = ^{hi_i[4:3], lo_i[7:5], lo_i[2:0]};

endmodule

// File: rtl/cam_pixel_packer.sv
// cam_pixel_packer: captures RGB565 byte pairs from a camera and writes RGB332.
// In: Pclk, rst, enable, data/href/vsync. Out: pix_data/addr/we, frame_done, overflow, busy.
module cam_pixel_packer
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int AW       = 15
) (
  input  logic          Pclk,
  input  logic          rst,
  input  logic          enable,
  input  logic [7:0]    data,
  input  logic          href,
  input  logic          vsync,
  output logic [7:0]    pix_data,
  output logic [AW-1:0] pix_addr,
  output logic          pix_we,
  output logic          frame_done,
  output logic          overflow,
  output logic          busy
);

  localparam int CW = $clog2(H_ACTIVE + 1);
  localparam logic [CW-1:0] H_LIM = CW'(H_ACTIVE);
  localparam logic [AW:0] FB_LIM = (AW + 1)'(H_ACTIVE * V_ACTIVE);

  cam_in_t    in_q;
  logic       vs_prev_q;
  cam_state_e state_q, state_d;
  logic       phase_q, phase_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    pix_data_q, pix_data_d;
  logic [AW-1:0] pix_addr_q, pix_addr_d;
  logic          pix_we_q, pix_we_d;
  logic          ovf_q, ovf_d;
  logic          done_q, busy_q;

  logic       vs_rise, vs_fall;
  logic       drop;
  logic [7:0] rgb332;

  cam_rgb_reduce u_rgb (
    .hi_i     (hi_q),
    .lo_i     (in_q.data),
    .rgb332_o (rgb332)
  );

  assign vs_rise = in_q.vsync & ~vs_prev_q;
  assign vs_fall = ~in_q.vsync & vs_prev_q;

  // Past the line width or with the buffer full, the pixel is lost.
  assign drop = (col_q >= H_LIM) || (cnt_q >= FB_LIM);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    col_d      = col_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    pix_data_d = pix_data_q;
    pix_addr_d = pix_addr_q;
    pix_we_d   = 1'b0;
    ovf_d      = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (in_q.vsync) state_d = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (vs_fall) begin
          state_d    = ST_CAPTURE;
          phase_d    = 1'b0;
          col_d      = '0;
          cnt_d      = '0;
          pix_addr_d = '0;
          ovf_d      = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (vs_rise) begin
          // Frame end beats a pixel completing in the same cycle.
          state_d = ST_DONE;
          phase_d = 1'b0;
          col_d   = '0;
        end else if (!in_q.href) begin
          // Blanking: an odd trailing byte is forgotten here.
          phase_d = 1'b0;
          col_d   = '0;
        end else if (!phase_q) begin
          hi_d    = in_q.data;
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (col_q < H_LIM) col_d = col_q + 1'b1;
          if (drop) begin
            ovf_d = 1'b1;
          end else begin
            pix_we_d   = 1'b1;
            pix_data_d = rgb332;
            pix_addr_d = cnt_q[AW-1:0];
            cnt_d      = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = enable ? ST_SYNC : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Pclk) begin
    if (rst) begin
      in_q       <= '0;
      vs_prev_q  <= 1'b0;
      state_q    <= ST_IDLE;
      phase_q    <= 1'b0;
      col_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      pix_data_q <= '0;
      pix_addr_q <= '0;
      pix_we_q   <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      in_q       <= '{data: data, href: href, vsync: vsync};
      vs_prev_q  <= in_q.vsync;
      state_q    <= state_d;
      phase_q    <= phase_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      pix_data_q <= pix_data_d;
      pix_addr_q <= pix_addr_d;
      pix_we_q   <= pix_we_d;
      ovf_q      <= ovf_d;
      done_q     <= (state_d == ST_DONE);
      busy_q     <= (state_d == ST_WAIT_FRAME) ||
                    (state_d == ST_CAPTURE);
    end
  end

  assign pix_data   = pix_data_q;
  assign pix_addr   = pix_addr_q;
  assign pix_we     = pix_we_q;
  assign frame_done = done_q;
  assign overflow   = ovf_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cam_pixel_packer.sv
// tb_cam_pixel_packer: randomized frames checked against a byte-stream model.
// Drives on the falling edge of Pclk and samples outputs there too.
module tb_cam_pixel_packer;

  localparam int H  = 160;
  localparam int V  = 120;
  localparam int AW = 15;
  localparam int FB = H * V;

  logic          Pclk = 1'b0;
  logic          rst, enable, href, vsync;
  logic [7:0]    data;
  logic [7:0]    pix_data;
  logic [AW-1:0] pix_addr;
  logic          pix_we, frame_done, overflow, busy;

  always #5 Pclk = ~Pclk;

  cam_pixel_packer #(.H_ACTIVE(H), .V_ACTIVE(V), .AW(AW)) dut (
    .Pclk       (Pclk),
    .rst        (rst),
    .enable     (enable),
    .data       (data),
    .href       (href),
    .vsync      (vsync),
    .pix_data   (pix_data),
    .pix_addr   (pix_addr),
    .pix_we     (pix_we),
    .frame_done (frame_done),
    .overflow   (overflow),
    .busy       (busy)
  );

  typedef struct {
    int d;
    int a;
  } wr_t;

  wr_t act_q[$];
  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  done_cnt = 0;
  bit  ovf_at_done = 0;
  int  m_addr;

  always @(negedge Pclk) begin
    if (pix_we === 1'b1) act_q.push_back('{int'(pix_data), int'(pix_addr)});
    if (frame_done === 1'b1) begin
      done_cnt++;
      ovf_at_done = overflow;
    end
  end

  // RGB565 -> RGB332 by field arithmetic.
  function automatic int rgb332(int hi, int lo);
    int r, g, b;
    r = hi / 8;
    g = (hi % 8) * 8 + lo / 32;
    b = lo % 32;
    return (r / 4) * 32 + (g / 8) * 4 + (b / 8);
  endfunction

  function automatic int diff_writes();
    int n = 0;
    if (act_q.size() != exp_q.size()) return -1;
    foreach (exp_q[i])
      if (act_q[i].d != exp_q[i].d || act_q[i].a != exp_q[i].a) n++;
    return n;
  endfunction

  task automatic drive(input int d, input bit h, input bit v);
    data  = 8'(d);
    href  = h;
    vsync = v;
    @(negedge Pclk);
  endtask

  task automatic vsync_pulse();
    repeat (4) drive(0, 0, 1);
    repeat (4) drive(0, 0, 0);
  endtask

  task automatic new_frame_model();
    m_addr = 0;
    act_q.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic model_pixels(input int bytes[$]);
    for (int p = 0; p < bytes.size() / 2; p++) begin
      if (p < H && m_addr < FB) begin
        exp_q.push_back('{rgb332(bytes[2*p], bytes[2*p+1]), m_addr});
        m_addr++;
      end
    end
  endtask

  task automatic send_line(input int n);
    int lb[$];
    int b;
    for (int i = 0; i < n; i++) begin
      b = int'($urandom_range(0, 255));
      lb.push_back(b);
      drive(b, 1, 0);
    end
    repeat (3) drive(0, 0, 0);
    model_pixels(lb);
  endtask

  task automatic test_reset();
    rst = 1; enable = 0;
    repeat (3) drive(0, 0, 0);
    tests++; if (pix_data !== 8'h00) begin fails++; $display("FAIL rst_pix_data got %h want 00", pix_data); end
    tests++; if (pix_addr !== '0) begin fails++; $display("FAIL rst_pix_addr got %0d want 0", pix_addr); end
    tests++; if (pix_we !== 1'b0) begin fails++; $display("FAIL rst_pix_we got %b want 0", pix_we); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow got %b want 0", overflow); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
    rst = 0;
    drive(0, 0, 0);
  endtask

  task automatic test_colors();
    enable = 1;
    repeat (2) drive(0, 0, 0);
    vsync_pulse();
    new_frame_model();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL col_busy got %b want 1", busy); end
    drive(8'hF8, 1, 0);
    drive(8'h1F, 1, 0);
    tests++; if (pix_we !== 1'b0) begin fails++; $display("FAIL col_early_we got %b want 0", pix_we); end
    drive(8'h07, 1, 0);
    tests++; if (pix_we !== 1'b1) begin fails++; $display("FAIL col_lat_we got %b want 1", pix_we); end
    tests++; if (pix_data !== 8'hE3) begin fails++; $display("FAIL col_e3 got %h want e3", pix_data); end
    tests++; if (pix_addr !== 15'd0) begin fails++; $display("FAIL col_addr0 got %0d want 0", pix_addr); end
    drive(8'hE0, 1, 0);
    drive(0, 0, 0);
    tests++; if (pix_data !== 8'h1C || pix_we !== 1'b1) begin fails++; $display("FAIL col_1c got %h/%b want 1c/1", pix_data, pix_we); end
    tests++; if (pix_addr !== 15'd1) begin fails++; $display("FAIL col_addr1 got %0d want 1", pix_addr); end
    repeat (3) drive(0, 0, 0);
    vsync_pulse();
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL col_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_full_frame();
    new_frame_model();
    for (int l = 0; l < V; l++) send_line(2 * H);
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL full_ovf got %b want 0", overflow); end
    tests++; if (pix_addr !== 15'(FB - 1)) begin fails++; $display("FAIL full_last_addr got %0d want %0d", pix_addr, FB - 1); end
    send_line(10);
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL full_sat_ovf got %b want 1", overflow); end
    tests++; if (pix_addr !== 15'(FB - 1)) begin fails++; $display("FAIL full_sat_addr got %0d want %0d", pix_addr, FB - 1); end
    tests++; if (act_q.size() !== FB) begin fails++; $display("FAIL full_count got %0d want %0d", act_q.size(), FB); end
    tests++; if (diff_writes() !== 0) begin fails++; $display("FAIL full_data got %0d bad want 0", diff_writes()); end
    tests++; if (done_cnt !== 0) begin fails++; $display("FAIL full_early_done got %0d want 0", done_cnt); end
    vsync_pulse();
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL full_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_long_line();
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL long_ovf_clr got %b want 0", overflow); end
    new_frame_model();
    send_line(330);
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL long_ovf got %b want 1", overflow); end
    send_line(20);
    tests++; if (diff_writes() !== 0) begin fails++; $display("FAIL long_data got %0d bad want 0", diff_writes()); end
    tests++; if (act_q.size() !== H + 10) begin fails++; $display("FAIL long_count got %0d want %0d", act_q.size(), H + 10); end
    if (act_q.size() > H) begin
      tests++; if (act_q[H].a !== H) begin fails++; $display("FAIL long_next_addr got %0d want %0d", act_q[H].a, H); end
    end
    vsync_pulse();
    tests++; if (ovf_at_done !== 1'b1) begin fails++; $display("FAIL long_ovf_done got %b want 1", ovf_at_done); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL long_ovf_next got %b want 0", overflow); end
  endtask

  task automatic test_odd_line();
    new_frame_model();
    send_line(7);
    send_line(6);
    send_line(5);
    tests++; if (act_q.size() !== 8) begin fails++; $display("FAIL odd_count got %0d want 8", act_q.size()); end
    tests++; if (diff_writes() !== 0) begin fails++; $display("FAIL odd_data got %0d bad want 0", diff_writes()); end
    vsync_pulse();
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL odd_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_vsync_wins();
    new_frame_model();
    send_line(4);
    drive(int'($urandom_range(0, 255)), 1, 0);
    drive(int'($urandom_range(0, 255)), 1, 1);
    repeat (3) drive(0, 0, 1);
    repeat (4) drive(0, 0, 0);
    tests++; if (act_q.size() !== 2) begin fails++; $display("FAIL vw_count got %0d want 2", act_q.size()); end
    tests++; if (diff_writes() !== 0) begin fails++; $display("FAIL vw_data got %0d bad want 0", diff_writes()); end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL vw_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int lb[$];
    int b;
    new_frame_model();
    for (int i = 0; i < 102; i++) begin
      b = int'($urandom_range(0, 255));
      if (i < 100) lb.push_back(b);
      drive(b, 1, 0);
    end
    model_pixels(lb);
    rst = 1;
    drive(int'($urandom_range(0, 255)), 1, 0);
    tests++; if ({pix_data, pix_addr, pix_we, frame_done, overflow, busy} !== '0) begin
      fails++; $display("FAIL mid_rst_out got %h/%0d/%b/%b/%b/%b want all 0", pix_data, pix_addr, pix_we, frame_done, overflow, busy);
    end
    drive(0, 0, 0);
    rst = 0; enable = 0;
    drive(0, 0, 0);
    tests++; if (act_q.size() !== 50) begin fails++; $display("FAIL mid_count got %0d want 50", act_q.size()); end
    tests++; if (diff_writes() !== 0) begin fails++; $display("FAIL mid_data got %0d bad want 0", diff_writes()); end
    vsync_pulse();
    tests++; if (busy !== 1'b0 || done_cnt !== 0) begin fails++; $display("FAIL mid_idle got busy %b done %0d want 0/0", busy, done_cnt); end
    enable = 1;
    repeat (2) drive(0, 0, 0);
    vsync_pulse();
    new_frame_model();
    send_line(12);
    tests++; if (diff_writes() !== 0 || act_q.size() !== 6) begin fails++; $display("FAIL mid_restart got %0d writes want 6", act_q.size()); end
    vsync_pulse();
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL mid_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_enable_drop();
    int n;
    new_frame_model();
    send_line(40);
    enable = 0;
    send_line(40);
    vsync_pulse();
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL en_done got %0d want 1", done_cnt); end
    tests++; if (diff_writes() !== 0 || act_q.size() !== 40) begin fails++; $display("FAIL en_data got %0d writes want 40", act_q.size()); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL en_idle_busy got %b want 0", busy); end
    n = act_q.size();
    vsync_pulse();
    send_line(10);
    vsync_pulse();
    tests++; if (act_q.size() !== n || done_cnt !== 1 || busy !== 1'b0) begin
      fails++; $display("FAIL en_ignore got writes %0d done %0d busy %b want %0d/1/0", act_q.size(), done_cnt, busy, n);
    end
  endtask

  initial begin
    rst = 1; enable = 0; href = 0; vsync = 0; data = '0;
    @(negedge Pclk);
    test_reset();
    test_colors();
    test_full_frame();
    test_long_line();
    test_odd_line();
    test_vsync_wins();
    test_reset_mid();
    test_enable_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
